seven_segment_mux_ctrl: RTL and testbench

Parametrised time-multiplexed driver for N-digit common-select seven-segment displays.
- Accepts packed hex nibbles plus per-digit decimal points through a load handshake.
- Commits new data only at frame boundaries, so the display never tears.
- Adds PWM brightness, anti-ghosting dead time, leading-zero suppression and configurable output polarity.
- Sits between the function-generator status/readout logic and the board display pins.

---
 rtl/seven_segment_mux_ctrl_pkg.sv | 16 +
 rtl/seven_segment_mux_ctrl_encoder.sv | 19 +
 rtl/seven_segment_mux_ctrl.sv | 141 ++++++++++++++
 tb/tb_seven_segment_mux_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_mux_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
package seven_seg_pkg;

    localparam int SEG_DP_BIT = 7;

    // Segment patterns G..A for hex digits 0..F, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] apply_polarity(input logic [7:0] segs, input logic active_low);
        return active_low ? ~segs : segs;
    endfunction

endpackage

// File: rtl/seven_segment_mux_ctrl_encoder.sv
// Hex nibble to active-high segment pattern; a blanked digit keeps its decimal point.
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] segs
);

    always_comb begin
        segs = 8'h00;
        segs[SEG_DP_BIT] = dp;
        if (!blank) begin
            segs[6:0] = SEG_TABLE[nibble];
        end
    end

endmodule

// File: rtl/seven_segment_mux_ctrl.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned data commit,
// PWM brightness, dead time between digits and leading-zero blanking.
module seven_segment_mux_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKDIV         = 100,
    parameter int DEAD_CYCLES    = 2,
    parameter int PWM_BITS       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] inp,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic                    pending,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [7:0]              data
);

    localparam int CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLKDIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_inp;
    logic [4*NUM_DIGITS-1:0] active_inp;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   active_dp;

    logic                    div_wrap;
    logic                    commit;
    logic                    dwell_live;
    logic                    pwm_gate;
    logic                    digit_en;
    logic [4*NUM_DIGITS-1:0] inp_shifted;
    logic [NUM_DIGITS-1:0]   dp_shifted;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    blank;
    logic [7:0]              segs;
    logic [NUM_DIGITS-1:0]   sel_next;
    logic [7:0]              data_next;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign commit   = div_wrap && (dig_idx == IDX_LAST);

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign dwell_live = 1'b1;
        end else begin : g_dead
            assign dwell_live = (div_cnt >= CNT_W'(DEAD_CYCLES));
        end
    endgenerate

    assign pwm_gate = (brightness == '1) || (pwm_cnt < brightness);
    assign digit_en = dwell_live && pwm_gate;

    // Shifting the current digit down to bit 0 also exposes every higher nibble for zero blanking.
    assign inp_shifted = active_inp >> {dig_idx, 2'b00};
    assign dp_shifted  = active_dp >> dig_idx;
    assign cur_nibble  = inp_shifted[3:0];
    assign cur_dp      = dp_shifted[0];
    assign blank       = lz_suppress && (dig_idx != '0) && (inp_shifted == '0);

    seven_seg_encoder u_encoder (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .blank  (blank),
        .segs   (segs)
    );

    always_comb begin
        sel_next  = '0;
        data_next = 8'h00;
        if (digit_en) begin
            sel_next  = NUM_DIGITS'(1) << dig_idx;
            data_next = segs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            dig_idx     <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
            pwm_cnt     <= pwm_cnt + 1'b1;
            frame_start <= commit;
            if (div_wrap) begin
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
            end
        end
    end

    // A load landing on the commit edge is kept pending; the commit still takes the old shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_inp <= '0;
            shadow_dp  <= '0;
            active_inp <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_inp <= inp;
                shadow_dp  <= dp;
            end
            if (commit && pending) begin
                active_inp <= shadow_inp;
                active_dp  <= shadow_dp;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= (SEL_ACTIVE_LOW != 0) ? '1 : '0;
            data <= apply_polarity(8'h00, SEG_ACTIVE_LOW != 0);
        end else begin
            sel  <= (SEL_ACTIVE_LOW != 0) ? ~sel_next : sel_next;
            data <= apply_polarity(data_next, SEG_ACTIVE_LOW != 0);
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_ctrl.sv
// Directed bench for seven_segment_mux_ctrl: 4 digits, 8-cycle dwell, 2 dead cycles,
// 2-bit PWM, active-low outputs. Cycle k = number of clock edges since the reset edge.
module tb_seven_segment_mux_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] inp;
    logic [3:0]  dp;
    logic        load;
    logic        lz_suppress;
    logic [1:0]  brightness;
    logic        pending;
    logic        frame_start;
    logic [3:0]  sel;
    logic [7:0]  data;

    seven_segment_mux_ctrl #(
        .NUM_DIGITS     (4),
        .CLKDIV         (8),
        .DEAD_CYCLES    (2),
        .PWM_BITS       (2),
        .SEG_ACTIVE_LOW (1),
        .SEL_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inp         (inp),
        .dp          (dp),
        .load        (load),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .pending     (pending),
        .frame_start (frame_start),
        .sel         (sel),
        .data        (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        int         cyc;
        logic [3:0] sel;
        logic [7:0] data;
        logic       pending;
        logic       fs;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] ph_inp    [6];
    logic [3:0]  ph_dp     [6];
    logic [1:0]  ph_bright [6];
    logic        ph_lz     [6];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic applyStimulus(input logic [15:0] v_inp, input logic [3:0] v_dp,
                                 input logic [1:0] v_bright, input logic v_lz);
        do_reset();
        brightness  = v_bright;
        lz_suppress = v_lz;
        inp         = v_inp;
        dp          = v_dp;
        load        = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic checkValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_sel, input logic [7:0] e_data,
                               input logic e_pending, input logic e_fs);
        checkValue({name, "_sel"}, {4'h0, sel}, {4'h0, e_sel});
        checkValue({name, "_data"}, data, e_data);
        checkValue({name, "_pending"}, {7'h0, pending}, {7'h0, e_pending});
        checkValue({name, "_frame_start"}, {7'h0, frame_start}, {7'h0, e_fs});
    endtask

    task automatic add_vec(input int p, input int k, input logic [3:0] s, input logic [7:0] d,
                           input logic pe, input logic f);
        vec_t v;
        v.phase   = p;
        v.cyc     = k;
        v.sel     = s;
        v.data    = d;
        v.pending = pe;
        v.fs      = f;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        inp         = 16'h0000;
        dp          = 4'h0;
        load        = 1'b0;
        lz_suppress = 1'b0;
        brightness  = 2'd3;

        ph_inp[0] = 16'h12A0; ph_dp[0] = 4'b0010; ph_bright[0] = 2'd3; ph_lz[0] = 1'b0;
        ph_inp[1] = 16'h12A0; ph_dp[1] = 4'b0010; ph_bright[1] = 2'd2; ph_lz[1] = 1'b0;
        ph_inp[2] = 16'h0030; ph_dp[2] = 4'b0000; ph_bright[2] = 2'd3; ph_lz[2] = 1'b1;
        ph_inp[3] = 16'h0000; ph_dp[3] = 4'b0000; ph_bright[3] = 2'd3; ph_lz[3] = 1'b1;
        ph_inp[4] = 16'h0000; ph_dp[4] = 4'b0100; ph_bright[4] = 2'd3; ph_lz[4] = 1'b1;
        ph_inp[5] = 16'h12A0; ph_dp[5] = 4'b0010; ph_bright[5] = 2'd1; ph_lz[5] = 1'b0;

        // Full brightness: frame 0 shows reset data (all "0"), frame 1 shows 12A0 with dp on digit 1.
        add_vec(0,  1, 4'hF, 8'hFF, 1, 0);
        add_vec(0,  2, 4'hF, 8'hFF, 1, 0);
        add_vec(0,  3, 4'hE, 8'hC0, 1, 0);
        add_vec(0, 10, 4'hF, 8'hFF, 1, 0);
        add_vec(0, 11, 4'hD, 8'hC0, 1, 0);
        add_vec(0, 31, 4'h7, 8'hC0, 1, 0);
        add_vec(0, 32, 4'h7, 8'hC0, 0, 1);
        add_vec(0, 33, 4'hF, 8'hFF, 0, 0);
        add_vec(0, 34, 4'hF, 8'hFF, 0, 0);
        add_vec(0, 35, 4'hE, 8'hC0, 0, 0);
        add_vec(0, 40, 4'hE, 8'hC0, 0, 0);
        add_vec(0, 41, 4'hF, 8'hFF, 0, 0);
        add_vec(0, 43, 4'hD, 8'h08, 0, 0);
        add_vec(0, 51, 4'hB, 8'hA4, 0, 0);
        add_vec(0, 59, 4'h7, 8'hF9, 0, 0);
        add_vec(0, 64, 4'h7, 8'hF9, 0, 1);
        add_vec(0, 65, 4'hF, 8'hFF, 0, 0);
        // Brightness 2: lit only while pwm_cnt is 0 or 1.
        add_vec(1,  3, 4'hF, 8'hFF, 1, 0);
        add_vec(1,  5, 4'hE, 8'hC0, 1, 0);
        add_vec(1,  6, 4'hE, 8'hC0, 1, 0);
        add_vec(1,  7, 4'hF, 8'hFF, 1, 0);
        add_vec(1, 37, 4'hE, 8'hC0, 0, 0);
        add_vec(1, 38, 4'hE, 8'hC0, 0, 0);
        add_vec(1, 39, 4'hF, 8'hFF, 0, 0);
        add_vec(1, 45, 4'hD, 8'h08, 0, 0);
        add_vec(1, 46, 4'hD, 8'h08, 0, 0);
        add_vec(1, 47, 4'hF, 8'hFF, 0, 0);
        add_vec(1, 53, 4'hB, 8'hA4, 0, 0);
        add_vec(1, 62, 4'h7, 8'hF9, 0, 0);
        add_vec(1, 63, 4'hF, 8'hFF, 0, 0);
        // Leading-zero suppression of 0030.
        add_vec(2,  3, 4'hE, 8'hC0, 1, 0);
        add_vec(2, 11, 4'hD, 8'hFF, 1, 0);
        add_vec(2, 35, 4'hE, 8'hC0, 0, 0);
        add_vec(2, 43, 4'hD, 8'hB0, 0, 0);
        add_vec(2, 51, 4'hB, 8'hFF, 0, 0);
        add_vec(2, 59, 4'h7, 8'hFF, 0, 0);
        // All zeros: only digit 0 shows "0".
        add_vec(3, 35, 4'hE, 8'hC0, 0, 0);
        add_vec(3, 43, 4'hD, 8'hFF, 0, 0);
        add_vec(3, 51, 4'hB, 8'hFF, 0, 0);
        add_vec(3, 59, 4'h7, 8'hFF, 0, 0);
        // Blanked digit 2 still shows its decimal point.
        add_vec(4, 35, 4'hE, 8'hC0, 0, 0);
        add_vec(4, 43, 4'hD, 8'hFF, 0, 0);
        add_vec(4, 51, 4'hB, 8'h7F, 0, 0);
        // Brightness 1: lit only while pwm_cnt is 0.
        add_vec(5, 37, 4'hE, 8'hC0, 0, 0);
        add_vec(5, 38, 4'hF, 8'hFF, 0, 0);
        add_vec(5, 45, 4'hD, 8'h08, 0, 0);
        add_vec(5, 46, 4'hF, 8'hFF, 0, 0);

        do_reset();
        checkOutput("reset", 4'hF, 8'hFF, 1'b0, 1'b0);

        for (int p = 0; p < 6; p++) begin
            $display("[TB] table phase %0d", p);
            applyStimulus(ph_inp[p], ph_dp[p], ph_bright[p], ph_lz[p]);
            foreach (vecs[i]) begin
                if (vecs[i].phase == p) begin
                    advance_to(vecs[i].cyc);
                    checkOutput($sformatf("p%0d_k%0d", p, vecs[i].cyc), vecs[i].sel, vecs[i].data,
                                vecs[i].pending, vecs[i].fs);
                end
            end
        end

        $display("[TB] brightness 0 keeps display dark");
        applyStimulus(16'h12A0, 4'b0010, 2'd0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            tick();
            checkValue($sformatf("dark_sel_k%0d", cyc), {4'h0, sel}, 8'h0F);
            checkValue($sformatf("dark_data_k%0d", cyc), data, 8'hFF);
        end

        $display("[TB] load collides with commit");
        applyStimulus(16'h2222, 4'b0000, 2'd3, 1'b0);
        advance_to(31);
        inp  = 16'h1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        checkOutput("coll_k32", 4'h7, 8'hC0, 1'b1, 1'b1);
        advance_to(35);
        checkOutput("coll_k35", 4'hE, 8'hA4, 1'b1, 1'b0);
        advance_to(43);
        checkOutput("coll_k43", 4'hD, 8'hA4, 1'b1, 1'b0);
        advance_to(63);
        checkOutput("coll_k63", 4'h7, 8'hA4, 1'b1, 1'b0);
        advance_to(64);
        checkOutput("coll_k64", 4'h7, 8'hA4, 1'b0, 1'b1);
        advance_to(67);
        checkOutput("coll_k67", 4'hE, 8'hF9, 1'b0, 1'b0);

        $display("[TB] reset mid-dwell of digit 2");
        applyStimulus(16'h12A0, 4'b0010, 2'd3, 1'b0);
        advance_to(45);
        inp  = 16'h0F0F;
        dp   = 4'b0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        advance_to(52);
        checkOutput("mid_k52", 4'hB, 8'hA4, 1'b1, 1'b0);
        do_reset();
        checkOutput("mid_reset", 4'hF, 8'hFF, 1'b0, 1'b0);
        advance_to(3);
        checkOutput("mid_restart", 4'hE, 8'hC0, 1'b0, 1'b0);
        while (!frame_start && cyc < 40) tick();
        checkValue("mid_fs_latency", 8'(cyc), 8'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
